conv_result_buffer: RTL and testbench
=====================================

Name: conv_result_buffer

Overview:
- Sits directly downstream of the convolution TPU core.
- Accepts one convolution result per handshake from the core's done/data_out pair and tags it with its output-map (row, col) coordinate. Applies optional ReLU and buffers results in a FIFO.
- Streams tagged results to the host side with valid/ready.
- Drives the core's ready input (in_ready) for back-pressure. Enforces a frame barrier: no new frame enters until the previous frame has fully drained.

Parameters:
- DATA_WIDTH, 16, result width; matches `DATA_WIDTH / data_t.
- OUT_DIM, 14, output map side length (MATRIX_DIM-CONV_DIM+1); frame = OUT_DIM*OUT_DIM results.
- DEPTH, 16, FIFO entries; must be a power of two, >=2.
- RELU, 0, 1 = clamp negative (two's-complement) results to 0 before storage.

Ports:
- clk, input, 1, clock.
- rst, input, 1, asynchronous active-high reset.
- clear, input, 1, synchronous flush: empties FIFO, zeroes counters, returns to RUN.
- in_valid, input, 1, result valid; connected to core done.
- in_data, input, DATA_WIDTH, result value; connected to core data_out.
- in_ready, output, 1, buffer can accept; connected to core ready.
- out_valid, output, 1, head entry valid.
- out_ready, input, 1, consumer accepts head.
- out_data, output, DATA_WIDTH, head result.
- out_row, output, $clog2(OUT_DIM), head row coordinate.
- out_col, output, $clog2(OUT_DIM), head column coordinate.
- out_last, output, 1, head is the final element of its frame.
- frame_done, output, 1, one-cycle pulse when the last element of a frame is popped.
- count, output, $clog2(DEPTH)+1, current occupancy.

Behaviour:
- Reset (async, rst=1):
  - FIFO empty; count=0; out_valid=0; in_ready=1.
  - out_data/out_row/out_col=0; out_last=0; frame_done=0.
  - Row/col counters = 0; state = RUN.
- States: RUN, DRAIN.
  - RUN: in_ready = !full.
  - DRAIN: in_ready = 0.
- Push rule: push = in_valid & in_ready. The entry stores:
  - data = (RELU && in_data[MSB]) ? 0 : in_data;
  - the current row and col;
  - last = (row==OUT_DIM-1 && col==OUT_DIM-1).
- Coordinate counters advance on each push, row-major:
  - col increments each push; on col==OUT_DIM-1, col wraps to 0 and row increments.
  - A push with last=1 wraps both counters to 0 and moves the state RUN->DRAIN in the same edge.
- Pop rule: pop = out_valid & out_ready.
  - out_* reflect the FIFO head combinationally from storage.
  - out_valid = (count != 0).
- Latency: an entry pushed at edge N is visible on out_valid after edge N. Minimum 1 cycle in-to-out; no combinational bypass.
- Simultaneous push and pop: count unchanged; both pointers advance.
- Full: in_ready=0 and in_valid is ignored, even if a pop occurs the same cycle (no same-cycle full bypass).
- Empty with out_ready=1: no pop, pointers hold.
- DRAIN->RUN transition, on the edge where the popped head has last=1:
  - frame_done=1 for the following cycle;
  - in_ready returns to 1 (FIFO is necessarily empty since in_ready was 0 throughout DRAIN).
- Pointers are $clog2(DEPTH) bits and wrap naturally. count tracks occupancy 0..DEPTH.
- clear priority: clear beats push and pop in the same cycle. Effects:
  - count=0; pointers=0; row=col=0; state=RUN; frame_done=0.
  - Contents are not observable afterwards.
- Reset mid-frame: all state lost; the next accepted result is tagged (0,0).

Test Plan:
- Single element: after reset, in_valid=1, in_data=0x0005 for 1 cycle, out_ready=1 -> next cycle out_valid=1, out_data=0x0005, row=0, col=0, out_last=0; count returns to 0 after pop.
- Fill/back-pressure: out_ready=0, push 17 values 1..17 with DEPTH=16 -> in_ready drops to 0 after the 16th push, count=16, value 17 not accepted. Then out_ready=1 -> pops 1..16 in order and in_ready returns to 1.
- Frame tagging and barrier with OUT_DIM=2, continuous in_valid, out_ready=1:
  - outputs (0,0),(0,1),(1,0),(1,1); last=1 only on (1,1);
  - in_ready=0 from the edge after the 4th push until the pop of (1,1);
  - frame_done pulses once;
  - the next push is tagged (0,0).
- ReLU with RELU=1: push 0xFFF0 and then 0x0010 -> outputs 0x0000 and 0x0010. With RELU=0, 0xFFF0 passes unchanged.
- Simultaneous push/pop at count=3: both asserted for 5 cycles -> count stays 3 and ordering is preserved.
- clear mid-frame: after 3 pushes with OUT_DIM=2, clear=1 together with in_valid=1 -> count=0, out_valid=0, and the push is dropped. The next push is tagged (0,0); async rst mid-stream gives the same result.

Source files
------------

// File: rtl/conv_result_buffer.sv
// Result buffer behind the convolution core: tags each result with its (row, col) position,
// applies optional ReLU, queues it in a FIFO and holds off the next frame until this one drains.
module conv_result_buffer #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned OUT_DIM    = 14,
  parameter int unsigned DEPTH      = 16,
  parameter bit          RELU       = 1'b0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clear,
  input  logic                       in_valid,
  input  logic [DATA_WIDTH-1:0]      in_data,
  output logic                       in_ready,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_WIDTH-1:0]      out_data,
  output logic [$clog2(OUT_DIM)-1:0] out_row,
  output logic [$clog2(OUT_DIM)-1:0] out_col,
  output logic                       out_last,
  output logic                       frame_done,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned CW = $clog2(OUT_DIM);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned NW = PW + 1;

  typedef enum logic {StRun, StDrain} state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [NW-1:0]   count_q, count_d;
  logic [CW-1:0]   row_q, row_d, col_q, col_d;
  logic            frame_done_q, frame_done_d;

  logic [DATA_WIDTH-1:0] mem_data [DEPTH];
  logic [CW-1:0]         mem_row  [DEPTH];
  logic [CW-1:0]         mem_col  [DEPTH];
  logic                  mem_last [DEPTH];

  logic                  full, push, pop, is_last, head_last;
  logic [DATA_WIDTH-1:0] wr_data;

  assign full      = (count_q == NW'(DEPTH));
  assign in_ready  = (state_q == StRun) && !full;
  assign out_valid = (count_q != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign is_last   = (row_q == CW'(OUT_DIM - 1)) && (col_q == CW'(OUT_DIM - 1));
  assign head_last = mem_last[rd_ptr_q];
  assign wr_data   = (RELU && in_data[DATA_WIDTH-1]) ? '0 : in_data;

  // Head fields are forced to zero while empty so stale storage never shows.
  assign out_data   = out_valid ? mem_data[rd_ptr_q] : '0;
  assign out_row    = out_valid ? mem_row[rd_ptr_q]  : '0;
  assign out_col    = out_valid ? mem_col[rd_ptr_q]  : '0;
  assign out_last   = out_valid ? head_last          : 1'b0;
  assign frame_done = frame_done_q;
  assign count      = count_q;

  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    row_d        = row_q;
    col_d        = col_q;
    frame_done_d = 1'b0;
    if (clear) begin
      state_d  = StRun;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      row_d    = '0;
      col_d    = '0;
    end else begin
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
        if (head_last) begin
          state_d      = StRun;
          frame_done_d = 1'b1;
        end
      end
      if (push) begin
        wr_ptr_d = wr_ptr_q + PW'(1);
        if (is_last) begin
          row_d   = '0;
          col_d   = '0;
          state_d = StDrain;
        end else if (col_q == CW'(OUT_DIM - 1)) begin
          col_d = '0;
          row_d = row_q + CW'(1);
        end else begin
          col_d = col_q + CW'(1);
        end
      end
      unique case ({push, pop})
        2'b10:   count_d = count_q + NW'(1);
        2'b01:   count_d = count_q - NW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StRun;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      row_q        <= '0;
      col_q        <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      row_q        <= row_d;
      col_q        <= col_d;
      frame_done_q <= frame_done_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !clear) begin
      mem_data[wr_ptr_q] <= wr_data;
      mem_row[wr_ptr_q]  <= row_q;
      mem_col[wr_ptr_q]  <= col_q;
      mem_last[wr_ptr_q] <= is_last;
    end
  end

endmodule

// File: tb/tb_conv_result_buffer.sv
// Bench for conv_result_buffer: a 14x14/no-ReLU instance and a 2x2/ReLU instance checked
// every cycle against a scoreboard model, plus a vector table and hand-written corner cases.
module tb_conv_result_buffer;

  localparam int DEPTH = 16;

  typedef struct {
    int data;
    int row;
    int col;
    int last;
  } ent_t;

  typedef struct {
    logic        vld;
    logic [15:0] data;
    logic        rdy;
    int          exp_count;
    int          exp_valid;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [1:0]       in_valid, out_ready, clear, in_ready, out_valid, out_last, frame_done;
  logic [1:0][15:0] in_data, out_data;
  logic [1:0][4:0]  count;
  logic [3:0]       row_a, col_a;
  logic [0:0]       row_b, col_b;

  int checks = 0;
  int errors = 0;

  int   od   [2] = '{14, 2};
  int   relu [2] = '{0, 1};
  int   m_st [2];
  int   m_row[2];
  int   m_col[2];
  int   m_fd [2];
  ent_t sb   [2][$];

  always #5 clk = ~clk;

  conv_result_buffer #(.DATA_WIDTH(16), .OUT_DIM(14), .DEPTH(DEPTH), .RELU(1'b0)) dut_a (
    .clk(clk), .rst(rst), .clear(clear[0]), .in_valid(in_valid[0]), .in_data(in_data[0]),
    .in_ready(in_ready[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .out_data(out_data[0]), .out_row(row_a), .out_col(col_a), .out_last(out_last[0]),
    .frame_done(frame_done[0]), .count(count[0])
  );

  conv_result_buffer #(.DATA_WIDTH(16), .OUT_DIM(2), .DEPTH(DEPTH), .RELU(1'b1)) dut_b (
    .clk(clk), .rst(rst), .clear(clear[1]), .in_valid(in_valid[1]), .in_data(in_data[1]),
    .in_ready(in_ready[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .out_data(out_data[1]), .out_row(row_b), .out_col(col_b), .out_last(out_last[1]),
    .frame_done(frame_done[1]), .count(count[1])
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Compare every output against the model, then advance the model across the coming edge.
  task automatic cycle();
    int   n, er, r, c, pop, push;
    ent_t h, e;
    #1;
    for (int d = 0; d < 2; d++) begin
      n  = sb[d].size();
      er = (m_st[d] == 0 && n < DEPTH) ? 1 : 0;
      r  = (d == 0) ? int'(row_a) : int'(row_b);
      c  = (d == 0) ? int'(col_a) : int'(col_b);
      chk($sformatf("dut%0d in_ready", d), in_ready[d], er);
      chk($sformatf("dut%0d out_valid", d), out_valid[d], (n != 0) ? 1 : 0);
      chk($sformatf("dut%0d count", d), count[d], n);
      chk($sformatf("dut%0d frame_done", d), frame_done[d], m_fd[d]);
      if (n != 0) begin
        h = sb[d][0];
      end else begin
        h = '{0, 0, 0, 0};
      end
      chk($sformatf("dut%0d out_data", d), out_data[d], h.data);
      chk($sformatf("dut%0d out_row", d), r, h.row);
      chk($sformatf("dut%0d out_col", d), c, h.col);
      chk($sformatf("dut%0d out_last", d), out_last[d], h.last);
    end
    for (int d = 0; d < 2; d++) begin
      n  = sb[d].size();
      er = (m_st[d] == 0 && n < DEPTH) ? 1 : 0;
      if (clear[d]) begin
        sb[d].delete();
        m_row[d] = 0;
        m_col[d] = 0;
        m_st[d]  = 0;
        m_fd[d]  = 0;
      end else begin
        pop     = (n != 0 && out_ready[d]) ? 1 : 0;
        push    = (in_valid[d] && er != 0) ? 1 : 0;
        m_fd[d] = 0;
        if (pop != 0) begin
          h = sb[d].pop_front();
          if (h.last != 0) begin
            m_st[d] = 0;
            m_fd[d] = 1;
          end
        end
        if (push != 0) begin
          e.data = (relu[d] != 0 && in_data[d][15]) ? 0 : int'(in_data[d]);
          e.row  = m_row[d];
          e.col  = m_col[d];
          e.last = (m_row[d] == od[d] - 1 && m_col[d] == od[d] - 1) ? 1 : 0;
          sb[d].push_back(e);
          if (e.last != 0) begin
            m_row[d] = 0;
            m_col[d] = 0;
            m_st[d]  = 1;
          end else if (m_col[d] == od[d] - 1) begin
            m_col[d] = 0;
            m_row[d] = m_row[d] + 1;
          end else begin
            m_col[d] = m_col[d] + 1;
          end
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    in_valid  = '0;
    out_ready = '0;
    clear     = '0;
    in_data   = '0;
    for (int d = 0; d < 2; d++) begin
      sb[d].delete();
      m_st[d]  = 0;
      m_row[d] = 0;
      m_col[d] = 0;
      m_fd[d]  = 0;
    end
    #3;
    rst = 1'b0;
    @(negedge clk);
  endtask

  vec_t vt [18];
  int   fd_cnt;
  int   rdy_at4;

  initial begin
    // Single element, then three queued entries followed by five cycles of push+pop at count 3.
    vt[0]  = '{1'b1, 16'h0005, 1'b1, 0, 0};
    vt[1]  = '{1'b0, 16'h0000, 1'b1, 1, 1};
    vt[2]  = '{1'b0, 16'h0000, 1'b0, 0, 0};
    vt[3]  = '{1'b1, 16'h000a, 1'b0, 0, 0};
    vt[4]  = '{1'b1, 16'h000b, 1'b0, 1, 1};
    vt[5]  = '{1'b1, 16'h000c, 1'b0, 2, 1};
    vt[6]  = '{1'b1, 16'h000d, 1'b1, 3, 1};
    vt[7]  = '{1'b1, 16'h000e, 1'b1, 3, 1};
    vt[8]  = '{1'b1, 16'h000f, 1'b1, 3, 1};
    vt[9]  = '{1'b1, 16'h0010, 1'b1, 3, 1};
    vt[10] = '{1'b1, 16'h0011, 1'b1, 3, 1};
    vt[11] = '{1'b0, 16'h0000, 1'b1, 3, 1};
    vt[12] = '{1'b0, 16'h0000, 1'b1, 2, 1};
    vt[13] = '{1'b0, 16'h0000, 1'b1, 1, 1};
    vt[14] = '{1'b0, 16'h0000, 1'b1, 0, 0};
    // Negative value passes unchanged without ReLU.
    vt[15] = '{1'b1, 16'hfff0, 1'b1, 0, 0};
    vt[16] = '{1'b0, 16'h0000, 1'b1, 1, 1};
    vt[17] = '{1'b0, 16'h0000, 1'b0, 0, 0};

    in_valid  = '0;
    out_ready = '0;
    clear     = '0;
    in_data   = '0;
    @(negedge clk);
    do_reset();
    cycle();

    foreach (vt[i]) begin
      in_valid[0]  = vt[i].vld;
      in_data[0]   = vt[i].data;
      out_ready[0] = vt[i].rdy;
      #1;
      chk($sformatf("tbl%0d count", i), count[0], vt[i].exp_count);
      chk($sformatf("tbl%0d out_valid", i), out_valid[0], vt[i].exp_valid);
      cycle();
    end

    // Fill with 1..17 under back-pressure, then drain in order.
    out_ready[0] = 1'b0;
    for (int i = 1; i <= 17; i++) begin
      in_valid[0] = 1'b1;
      in_data[0]  = 16'(i);
      cycle();
    end
    in_valid[0] = 1'b0;
    #1;
    chk("fill count", count[0], 16);
    chk("fill in_ready", in_ready[0], 0);
    out_ready[0] = 1'b1;
    for (int i = 0; i < 16; i++) cycle();
    #1;
    chk("drain count", count[0], 0);
    chk("drain in_ready", in_ready[0], 1);

    // 2x2 frame with continuous input: barrier, single frame_done, next push at (0,0).
    fd_cnt       = 0;
    rdy_at4      = -1;
    in_valid[1]  = 1'b1;
    out_ready[1] = 1'b1;
    for (int i = 0; i < 6; i++) begin
      in_data[1] = 16'(100 + i);
      #1;
      if (frame_done[1]) fd_cnt++;
      if (i == 4) rdy_at4 = int'(in_ready[1]);
      cycle();
    end
    in_valid[1] = 1'b0;
    chk("frame_done pulses", fd_cnt, 1);
    chk("barrier in_ready", rdy_at4, 0);
    for (int i = 0; i < 3; i++) cycle();

    // ReLU instance clamps negatives.
    in_valid[1] = 1'b1;
    in_data[1]  = 16'hfff0;
    cycle();
    in_data[1] = 16'h0010;
    #1;
    chk("relu neg", out_data[1], 0);
    cycle();
    in_valid[1] = 1'b0;
    #1;
    chk("relu pos", out_data[1], 16'h0010);
    for (int i = 0; i < 2; i++) cycle();

    // Clear mid-frame beats a simultaneous push.
    clear[1] = 1'b1;
    cycle();
    clear[1]     = 1'b0;
    out_ready[1] = 1'b0;
    in_valid[1]  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_data[1] = 16'(16'h20 + i);
      cycle();
    end
    clear[1]   = 1'b1;
    in_data[1] = 16'h0077;
    cycle();
    clear[1]    = 1'b0;
    in_valid[1] = 1'b0;
    #1;
    chk("clear count", count[1], 0);
    chk("clear out_valid", out_valid[1], 0);
    in_valid[1]  = 1'b1;
    in_data[1]   = 16'h0055;
    out_ready[1] = 1'b1;
    cycle();
    in_valid[1] = 1'b0;
    #1;
    chk("post-clear data", out_data[1], 16'h0055);
    chk("post-clear row", row_b, 0);
    chk("post-clear col", col_b, 0);
    cycle();

    // Asynchronous reset mid-stream.
    out_ready[1] = 1'b0;
    in_valid[1]  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_data[1] = 16'(16'h30 + i);
      cycle();
    end
    do_reset();
    cycle();
    in_valid[1]  = 1'b1;
    in_data[1]   = 16'h0066;
    out_ready[1] = 1'b1;
    cycle();
    in_valid[1] = 1'b0;
    #1;
    chk("post-reset data", out_data[1], 16'h0066);
    chk("post-reset row", row_b, 0);
    chk("post-reset col", col_b, 0);
    for (int i = 0; i < 2; i++) cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
